// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash READ responder.
// FAST_READ_EN enables acceptance of the 0x0B fast-read command.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYCLES  = 8;

`ifdef FAST_READ_EN
  localparam bit FAST_READ_ON = 1'b1;
`else
  localparam bit FAST_READ_ON = 1'b0;
`endif

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer with one edge-detect flop producing rise/fall strobes.
module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target answering flash READ (0x03) from a request/valid byte memory.
// Define FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int   ADDR_WIDTH  = 24,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  input  logic                  mem_valid,
  output logic                  busy,
  output logic                  underrun
);

  state_t r_state, w_stateNext;

  logic w_sckSync, w_sckRise, w_sckFall;
  logic w_csSync, w_csRise, w_csFall;
  logic w_unused;

  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [22:0]            r_shiftIn;
  logic [23:0]            w_shiftInNext;
  logic [4:0]             r_bitCnt;
  logic [7:0]             r_shiftOut;
  logic [2:0]             r_outCnt;
  logic [7:0]             r_bufData;
  logic                   r_bufValid, r_pending, r_skip, r_fast;
  logic                   r_miso, r_memReq, r_underrun;
  logic [ADDR_WIDTH-1:0]  r_memAddr;

  logic w_cmdRead, w_cmdFast, w_shiftPhase, w_cmdDone, w_addrDone;
  logic w_dataFall, w_loadByte, w_memHit, w_bufReady, w_advance;
  logic [7:0] w_nextByte;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sckSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi_clk),
    .o_sync (w_sckSync),
    .o_rise (w_sckRise),
    .o_fall (w_sckFall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(spi_cs_n),
    .o_sync (w_csSync),
    .o_rise (w_csRise),
    .o_fall (w_csFall)
  );

  assign w_unused = &{1'b0, w_sckSync, w_csRise};

  assign w_shiftInNext = {r_shiftIn, r_mosiSync[SYNC_STAGES-1]};
  assign w_cmdRead     = (w_shiftInNext[7:0] == CMD_READ);
  assign w_cmdFast     = FAST_READ_ON && (w_shiftInNext[7:0] == CMD_FAST_READ);

  assign w_shiftPhase = w_sckRise & ~w_csSync & (r_state inside {CMD, ADDR, DUMMY});
  assign w_cmdDone    = w_shiftPhase & (r_state == CMD) & (r_bitCnt == 5'd7);
  assign w_addrDone   = w_shiftPhase & (r_state == ADDR) & (r_bitCnt == 5'd23);
  assign w_dataFall   = w_sckFall & ~w_csSync & (r_state == DATA);
  assign w_loadByte   = w_dataFall & (r_outCnt == 3'd0);

  // A response arriving on the very cycle a byte is due is forwarded directly.
  assign w_memHit   = mem_valid & r_pending & ~w_csSync;
  assign w_bufReady = r_bufValid | (w_memHit & ~r_skip);
  assign w_nextByte = r_bufValid ? r_bufData : (w_bufReady ? mem_data : 8'hFF);
  assign w_advance  = (w_loadByte & w_bufReady) | (w_memHit & r_skip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_csSync) begin
      w_stateNext = IDLE;
    end else if (w_csFall) begin
      w_stateNext = CMD;
    end else if (w_sckRise) begin
      case (r_state)
        CMD:     if (r_bitCnt == 5'd7) w_stateNext = (w_cmdRead || w_cmdFast) ? ADDR : IGNORE;
        ADDR:    if (r_bitCnt == 5'd23) w_stateNext = r_fast ? DUMMY : DATA;
        DUMMY:   if (r_bitCnt == 5'(DUMMY_CYCLES - 1)) w_stateNext = DATA;
        default: ;
      endcase
    end
  end

  // An underrun leaves the late response outstanding; it is swallowed, then the next address is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosiSync <= '0;
      r_shiftIn  <= '0;
      r_bitCnt   <= '0;
      r_shiftOut <= '0;
      r_outCnt   <= '0;
      r_bufData  <= '0;
      r_bufValid <= 1'b0;
      r_pending  <= 1'b0;
      r_skip     <= 1'b0;
      r_fast     <= 1'b0;
      r_miso     <= IDLE_MISO;
      r_memReq   <= 1'b0;
      r_memAddr  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_memReq   <= 1'b0;
      if (w_csSync) begin
        r_miso     <= IDLE_MISO;
        r_pending  <= 1'b0;
        r_skip     <= 1'b0;
        r_bufValid <= 1'b0;
        r_bitCnt   <= '0;
      end else begin
        if (w_csFall) r_bitCnt <= '0;
        if (w_shiftPhase) begin
          r_shiftIn <= w_shiftInNext[22:0];
          r_bitCnt  <= (w_stateNext != r_state) ? 5'd0 : r_bitCnt + 5'd1;
        end
        if (w_cmdDone) r_fast <= w_cmdFast;
        if (w_addrDone) begin
          r_memAddr  <= w_shiftInNext[ADDR_WIDTH-1:0];
          r_memReq   <= 1'b1;
          r_pending  <= 1'b1;
          r_outCnt   <= '0;
          r_bufValid <= 1'b0;
          r_skip     <= 1'b0;
        end
        if (w_memHit) begin
          r_pending <= 1'b0;
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (!w_loadByte) begin
            r_bufData  <= mem_data;
            r_bufValid <= 1'b1;
          end
        end
        if (w_loadByte) begin
          r_miso     <= w_nextByte[7];
          r_shiftOut <= {w_nextByte[6:0], 1'b0};
          r_outCnt   <= 3'd7;
          r_bufValid <= 1'b0;
          if (!w_bufReady) begin
            r_underrun <= 1'b1;
            r_skip     <= 1'b1;
          end
        end else if (w_dataFall) begin
          r_miso     <= r_shiftOut[7];
          r_shiftOut <= {r_shiftOut[6:0], 1'b0};
          r_outCnt   <= r_outCnt - 3'd1;
        end
        if (w_advance) begin
          r_memAddr <= r_memAddr + ADDR_WIDTH'(1);
          r_memReq  <= 1'b1;
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign spi_miso = r_miso;
  assign mem_req  = r_memReq;
  assign mem_addr = r_memAddr;
  assign busy     = (r_state != IDLE);
  assign underrun = r_underrun;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder; honours FAST_READ_EN.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic        mem_req, mem_valid, busy, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;

  int checks = 0;
  int errors = 0;
  int halfPeriod = 8;
  int memLat = 1;
  int memCnt = 0;
  bit memActive = 0;
  logic [23:0] memAddrLatched = '0;
  logic [23:0] reqLog[$];
  logic [31:0] hdrRx;

  spi_flash_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_valid(mem_valid),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Memory model: returns addr[7:0] memLat cycles after each request.
  initial begin
    mem_valid = 1'b0;
    mem_data  = 8'h00;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (mem_req === 1'b1) begin
        reqLog.push_back(mem_addr);
        memAddrLatched = mem_addr;
        memCnt = memLat;
        memActive = 1;
      end else if (memActive) begin
        memCnt--;
        if (memCnt <= 0) begin
          mem_valid = 1'b1;
          mem_data  = memAddrLatched[7:0];
          memActive = 0;
        end
      end
    end
  end

  task automatic spiBits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (halfPeriod) @(negedge clk);
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_miso};
      repeat (halfPeriod) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic startRead(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_cs_n = 1'b0;
    repeat (halfPeriod) @(negedge clk);
    spiBits(cmd, 8, rx);         hdrRx[31:24] = rx;
    spiBits(addr[23:16], 8, rx); hdrRx[23:16] = rx;
    spiBits(addr[15:8], 8, rx);  hdrRx[15:8]  = rx;
    spiBits(addr[7:0], 8, rx);   hdrRx[7:0]   = rx;
  endtask

  task automatic endCs();
    repeat (halfPeriod) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso got %b expected 0", spi_miso); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("[TB] FAIL reset_addr got %h expected 000000", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got %b expected 0", underrun); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b expected 0", busy); end
  endtask

  task automatic test_read();
    logic [7:0] rx;
    halfPeriod = 8; memLat = 1; reqLog.delete();
    startRead(8'h03, 24'h000000);
    checks++; if (hdrRx !== 32'h0) begin errors++; $display("[TB] FAIL read_hdr_miso got %h expected 00000000", hdrRx); end
    for (int b = 0; b < 4; b++) begin
      spiBits(8'h00, 8, rx);
      checks++; if (rx !== 8'(b)) begin errors++; $display("[TB] FAIL read_byte%0d got %h expected %h", b, rx, 8'(b)); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy got %b expected 1", busy); end
    endCs();
    // The closing SCK fall of the last bit already prefetches address 5.
    checks++; if (reqLog.size() != 6) begin errors++; $display("[TB] FAIL read_req_count got %0d expected 6", reqLog.size()); end
    for (int i = 0; i < 5 && i < reqLog.size(); i++) begin
      checks++; if (reqLog[i] !== 24'(i)) begin errors++; $display("[TB] FAIL read_req%0d got %h expected %h", i, reqLog[i], 24'(i)); end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL read_underrun got %b expected 0", underrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_end got %b expected 0", busy); end
  endtask

  task automatic test_ignore();
    logic [7:0] rx;
    halfPeriod = 8; memLat = 1; reqLog.delete();
    startRead(8'h9F, 24'hA5C33C);
    checks++; if (hdrRx !== 32'h0) begin errors++; $display("[TB] FAIL ignore_hdr_miso got %h expected 00000000", hdrRx); end
    spiBits(8'h5A, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("[TB] FAIL ignore_tail_miso got %h expected 00", rx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ignore_busy got %b expected 1", busy); end
    endCs();
    checks++; if (reqLog.size() != 0) begin errors++; $display("[TB] FAIL ignore_req_count got %0d expected 0", reqLog.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_busy_end got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx;
    int dropped;
    halfPeriod = 8; memLat = 1; reqLog.delete();
    startRead(8'h03, 24'h000040);
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h40) begin errors++; $display("[TB] FAIL abort_byte0 got %h expected 40", rx); end
    spiBits(8'h00, 3, rx);
    checks++; if (rx[2:0] !== 3'b010) begin errors++; $display("[TB] FAIL abort_partial got %b expected 010", rx[2:0]); end
    spi_cs_n = 1'b1;
    dropped = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin dropped = k; break; end
    end
    checks++; if (dropped == 0 || dropped > 4) begin errors++; $display("[TB] FAIL abort_busy_drop got %0d cycles expected 1..4", dropped); end
    repeat (30) @(negedge clk);
    reqLog.delete();
    startRead(8'h03, 24'h000100);
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("[TB] FAIL restart_byte0 got %h expected 00", rx); end
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h01) begin errors++; $display("[TB] FAIL restart_byte1 got %h expected 01", rx); end
    endCs();
    checks++; if (reqLog.size() == 0 || reqLog[0] !== 24'h000100) begin errors++; $display("[TB] FAIL restart_first_req got %h expected 000100", reqLog.size() ? reqLog[0] : 24'hx); end
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    logic [7:0] expByte [3];
    logic [23:0] expAddr [3];
    expByte = '{8'hFE, 8'hFF, 8'h00};
    expAddr = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    halfPeriod = 8; memLat = 1; reqLog.delete();
    startRead(8'h03, 24'hFFFFFE);
    for (int b = 0; b < 3; b++) begin
      spiBits(8'h00, 8, rx);
      checks++; if (rx !== expByte[b]) begin errors++; $display("[TB] FAIL wrap_byte%0d got %h expected %h", b, rx, expByte[b]); end
    end
    endCs();
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= reqLog.size() || reqLog[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL wrap_req%0d got %h expected %h", i, (i < reqLog.size()) ? reqLog[i] : 24'hx, expAddr[i]); end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL wrap_underrun got %b expected 0", underrun); end
  endtask

  task automatic test_fast_read();
    logic [7:0] rx;
    halfPeriod = 8; memLat = 40; reqLog.delete();
    startRead(8'h0B, 24'h000020);
    checks++; if (hdrRx !== 32'h0) begin errors++; $display("[TB] FAIL fast_hdr_miso got %h expected 00000000", hdrRx); end
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("[TB] FAIL fast_dummy_miso got %h expected 00", rx); end
`ifdef FAST_READ_EN
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h20) begin errors++; $display("[TB] FAIL fast_byte0 got %h expected 20", rx); end
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h21) begin errors++; $display("[TB] FAIL fast_byte1 got %h expected 21", rx); end
    endCs();
    checks++; if (reqLog.size() == 0 || reqLog[0] !== 24'h000020) begin errors++; $display("[TB] FAIL fast_first_req got %h expected 000020", reqLog.size() ? reqLog[0] : 24'hx); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL fast_underrun got %b expected 0", underrun); end
`else
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("[TB] FAIL fast_ignored_miso got %h expected 00", rx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fast_ignored_busy got %b expected 1", busy); end
    endCs();
    checks++; if (reqLog.size() != 0) begin errors++; $display("[TB] FAIL fast_ignored_reqs got %0d expected 0", reqLog.size()); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fast_busy_end got %b expected 0", busy); end
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    halfPeriod = 5; memLat = 40; reqLog.delete();
    startRead(8'h03, 24'h000010);
    spiBits(8'h00, 8, rx);
    checks++; if (rx !== 8'hFF) begin errors++; $display("[TB] FAIL underrun_byte0 got %h expected FF", rx); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL underrun_flag got %b expected 1", underrun); end
    endCs();
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL underrun_sticky got %b expected 1", underrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL underrun_busy_end got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_ignore();
    test_back_to_back();
    test_wrap();
    test_fast_read();
    test_underrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
